l1c_data_nway: RTL

Parametrised N-way set-associative L1 data cache: write-through, no-write-allocate, with pseudo-LRU replacement and a one-cycle whole-cache invalidate. It sits between the CPU data port and the CPU-wrapper master port, which handles AXI. Compared with the current 2-way, 32-set, 4-word data cache, it generalises ways, sets and line length. Tag and data storage are internal flip-flop arrays, so any legal geometry needs no SRAM macro.

---
 rtl/l1c_data_nway_if.sv | 32 +++
 rtl/l1c_data_nway.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1c_data_nway_if.sv
// rtl/l1c_data_nway_if.sv - CPU data port and memory-side bus bundle for l1c_data_nway
interface l1c_data_nway_if;
    logic        core_req;
    logic [31:0] core_addr;
    logic [3:0]  core_write;
    logic [31:0] core_in;
    logic        flush;
    logic [31:0] core_out;
    logic        core_done;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_bvalid;

    modport master (
        output core_req, core_addr, core_write, core_in, flush,
        output mem_rdata, mem_rvalid, mem_bvalid,
        input  core_out, core_done,
        input  mem_req, mem_write, mem_addr, mem_wstrb, mem_wdata
    );

    modport slave (
        input  core_req, core_addr, core_write, core_in, flush,
        input  mem_rdata, mem_rvalid, mem_bvalid,
        output core_out, core_done,
        output mem_req, mem_write, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/l1c_data_nway.sv
// rtl/l1c_data_nway.sv - N-way write-through L1 data cache with tree-PLRU; L1C_PERF_CNT_EN adds request/miss counters
module l1c_data_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    l1c_data_nway_if.slave    bus
`ifdef L1C_PERF_CNT_EN
    ,
    output logic [31:0]       read_req_cnt,
    output logic [31:0]       write_req_cnt,
    output logic [31:0]       read_miss_cnt,
    output logic [31:0]       write_miss_cnt
`endif
);
    localparam int WW  = $clog2(WAYS);
    localparam int BW  = $clog2(LINE_WORDS);
    localparam int OFF = BW + 2;
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 32 - IDX - OFF;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESPOND, WRITE} state_t;
    state_t state, state_d;

    logic [TAG-1:0]  tags  [SETS][WAYS];
    logic [31:0]     data  [SETS][WAYS][LINE_WORDS];
    logic [WAYS-1:0] valid [SETS];
    logic [WAYS-2:0] plru  [SETS];

    logic [31:0]   addr_q, wdata_q, capt_q;
    logic [3:0]    wstrb_q;
    logic [WW-1:0] victim_q;
    logic [BW-1:0] beat_q;

    logic [IDX-1:0] idx;
    logic [TAG-1:0] tag_q;
    logic [BW-1:0]  wsel;
    logic           is_read, hit, last_beat;
    logic [WW-1:0]  hit_way, vict;

    // Heap-ordered tree: node n has children 2n and 2n+1; a bit of 1 steers to the upper child.
    function automatic logic [WW-1:0] plru_victim(input logic [WAYS-2:0] b);
        int node;
        node = 1;
        for (int l = 0; l < WW; l++) node = 2 * node + int'(b[node-1]);
        return WW'(node - WAYS);
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] b, input logic [WW-1:0] way);
        logic [WAYS-2:0] r;
        logic            dir;
        int              node;
        r    = b;
        node = 1;
        for (int l = 0; l < WW; l++) begin
            dir         = way[WW-1-l];
            r[node-1]   = ~dir;
            node        = 2 * node + int'(dir);
        end
        return r;
    endfunction

    assign idx       = addr_q[OFF+IDX-1:OFF];
    assign tag_q     = addr_q[31:OFF+IDX];
    assign wsel      = addr_q[OFF-1:2];
    assign is_read   = (wstrb_q == 4'hf);
    assign last_beat = (beat_q == BW'(LINE_WORDS - 1));
    assign bus.mem_wstrb = wstrb_q;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vict    = plru_victim(plru[idx]);
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && tags[idx][w] == tag_q) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins over the PLRU choice.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[idx][w]) vict = WW'(w);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d       = state;
        bus.core_done = 1'b0;
        bus.core_out  = '0;
        bus.mem_req   = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            IDLE: begin
                if (!bus.flush && bus.core_req) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (!is_read) begin
                    state_d = WRITE;
                end else if (hit) begin
                    bus.core_done = 1'b1;
                    bus.core_out  = data[idx][hit_way][wsel];
                    state_d       = IDLE;
                end else begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {addr_q[31:OFF], beat_q, 2'b00};
                if (bus.mem_rvalid && last_beat) state_d = RESPOND;
            end
            RESPOND: begin
                bus.core_done = 1'b1;
                bus.core_out  = capt_q;
                state_d       = IDLE;
            end
            WRITE: begin
                bus.mem_req   = 1'b1;
                bus.mem_write = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                if (bus.mem_bvalid) begin
                    bus.core_done = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= 4'hf;
            capt_q   <= '0;
            victim_q <= '0;
            beat_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                plru[s]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid[s] <= '0;
                            plru[s]  <= '0;
                        end
                    end else if (bus.core_req) begin
                        addr_q  <= bus.core_addr;
                        wstrb_q <= bus.core_write;
                        wdata_q <= bus.core_in;
                    end
                end
                LOOKUP: begin
                    if (hit) plru[idx] <= plru_touch(plru[idx], hit_way);
                    if (is_read && !hit) begin
                        victim_q <= vict;
                        beat_q   <= '0;
                    end
                end
                REFILL: begin
                    if (bus.mem_rvalid) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == wsel) capt_q <= bus.mem_rdata;
                        if (last_beat) begin
                            valid[idx][victim_q] <= 1'b1;
                            plru[idx]            <= plru_touch(plru[idx], victim_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (state == LOOKUP && !is_read && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (!wstrb_q[b]) data[idx][hit_way][wsel][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
        if (state == REFILL && bus.mem_rvalid) begin
            data[idx][victim_q][beat_q] <= bus.mem_rdata;
            if (last_beat) tags[idx][victim_q] <= tag_q;
        end
    end

`ifdef L1C_PERF_CNT_EN
    logic acc_read, acc_write;
    assign acc_read  = (state == IDLE) && !bus.flush && bus.core_req && (bus.core_write == 4'hf);
    assign acc_write = (state == IDLE) && !bus.flush && bus.core_req && (bus.core_write != 4'hf);

    always_ff @(posedge clk) begin
        if (rst) begin
            read_req_cnt   <= '0;
            write_req_cnt  <= '0;
            read_miss_cnt  <= '0;
            write_miss_cnt <= '0;
        end else begin
            if (acc_read && read_req_cnt != 32'hffffffff)   read_req_cnt  <= read_req_cnt + 1;
            if (acc_write && write_req_cnt != 32'hffffffff) write_req_cnt <= write_req_cnt + 1;
            if (state == LOOKUP && !hit && is_read && read_miss_cnt != 32'hffffffff)
                read_miss_cnt <= read_miss_cnt + 1;
            if (state == LOOKUP && !hit && !is_read && write_miss_cnt != 32'hffffffff)
                write_miss_cnt <= write_miss_cnt + 1;
        end
    end
`endif
endmodule
